enc8b10b_lanes: RTL and testbench
=================================

Name: enc8b10b_lanes

Overview:
- Registered, multi-lane 8b/10b encoder. Encodes LANES bytes per beat using the Widmer–Franaszek 5B/6B + 3B/4B tables.
- Running disparity (RD) is chained lane 0 → LANES-1 within a beat and held in a register across beats.
- Sits between the framing logic and the SERDES/serializer. Has valid/ready handshakes, optional automatic idle-comma insertion and illegal-K error reporting.

Parameters:
- LANES, 2, number of byte lanes per beat (1..8).
- IDLE_EN, 1, 1 = emit IDLE_CHAR on all lanes when no input beat is available and the output can advance.
- IDLE_CHAR, 9'h1BC, {K,byte} inserted as idle (default K28.5).
- ERRW, 16, width of the saturating illegal-K counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  8*LANES  byte per lane; lane n = [8n+7:8n]
- in_k  in  LANES  control flag per lane
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  10*LANES  code group per lane; lane n = [10n+9:10n], bit order {j,h,g,f,i,e,d,c,b,a}
- out_idle  out  1  current output beat is an inserted idle
- out_kerr  out  LANES  per-lane illegal-K flag for current output beat
- rd_clr  in  1  synchronous: force RD to negative
- rd_out  out  1  current RD register (0 = RD-, 1 = RD+)
- err_cnt  out  ERRW  saturating count of illegal-K lanes accepted
- err_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_idle=0, out_kerr=0, rd_out=0 (RD-), err_cnt=0. Release is synchronous to clk.
- in_ready = !out_valid | out_ready (one output register, no skid; combinational ready path).
- "Advance" = in_ready. On advance, one of the following applies:
  - If in_valid: encode the in_data/in_k beat. out_valid←1, out_idle←0.
  - Else if IDLE_EN: encode IDLE_CHAR on every lane. out_valid←1, out_idle←1.
  - Else: out_valid←0. out_data, RD and out_kerr hold.
- No advance (out_valid & !out_ready): all outputs and RD hold.
- Latency: accepted beat appears on out_data on the next clock edge (1 cycle).
- Encoding per lane:
  - Standard tables including the alternate A7 encoding for Dx.7.
  - Lane n is encoded with the RD produced by lane n-1; lane 0 uses the RD register.
  - RD register ← disparity after lane LANES-1, updated only on beats that load out_data.
- Illegal K: lane has K=1 and is neither K28.x nor K23.7/K27.7/K29.7/K30.7.
  - Lane is still encoded by the table equations.
  - out_kerr[n]←1 for that beat.
  - Idle beats always have out_kerr=0.
- err_cnt: on each accepted input beat, add popcount(illegal-K lanes), saturating at 2^ERRW-1.
  - err_clr has priority: counter ←0; that cycle's increments are discarded.
- rd_clr: RD← 0 takes effect before encoding.
  - If rd_clr coincides with an advance, that beat is encoded starting from RD- and RD then takes the beat's ending disparity.
  - Without an advance, RD←0.
- rd_clr/err_clr do not affect out_valid or held out_data.

Test Plan:
- Reset, LANES=1, IDLE_EN=1, out_ready=1, in_valid=0 → out_data alternates 0x17C (K28.5 RD-), 0x283 (RD+), …; out_idle=1; rd_out toggles each beat.
- LANES=2, RD-, beat {lane1=D21.5 0xB5 K0, lane0=K28.5} → lane0=0x17C, lane1=0x155 (balanced); rd_out=1 after beat.
- out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_data/rd_out frozen; on out_ready=1 the pending beat is accepted next edge, nothing lost or duplicated.
- in_k=1 with byte 0x00 (K0.0) on lane 0 → out_kerr[0]=1, err_cnt+1. Saturation at ERRW=4: 20 illegal lanes → err_cnt=15. err_clr with a simultaneous illegal lane → 0.
- rd_clr asserted together with a K28.5 beat while rd_out=1 → emitted 0x17C (RD- form), rd_out=1 afterwards.
- IDLE_EN=0, in_valid pulses one beat → out_valid high one cycle then 0; assert rst mid-stream → out_valid=0, rd_out=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/enc8b10b_lanes.sv
// enc8b10b_lanes: registered multi-lane 8b/10b encoder (5B/6B + 3B/4B).
// Running disparity is chained from lane 0 up to lane LANES-1 within a beat and
// held in a register across beats. It can insert idle commas automatically and
// flags control characters that are not legal K codes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input beat handshake (ready = !out_valid | out_ready)
//   in_data, in_k   byte and control flag per lane, lane n = in_data[8n+7:8n]
//   out_valid/ready output beat handshake
//   out_data        code group per lane, lane n = [10n+9:10n], {j,h,g,f,i,e,d,c,b,a}
//   out_idle        current output beat is an inserted idle
//   out_kerr        per-lane illegal-K flag for the current output beat
//   rd_clr          synchronous force of the running disparity to RD-
//   rd_out          running disparity register (0 = RD-, 1 = RD+)
//   err_cnt/err_clr saturating count of illegal-K lanes accepted, synchronous clear
module enc8b10b_lanes #(
  parameter int unsigned LANES     = 2,
  parameter bit          IDLE_EN   = 1'b1,
  parameter logic [8:0]  IDLE_CHAR = 9'h1BC,
  parameter int unsigned ERRW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   out_data,
  output logic                  out_idle,
  output logic [LANES-1:0]      out_kerr,
  input  logic                  rd_clr,
  output logic                  rd_out,
  output logic [ERRW-1:0]       err_cnt,
  input  logic                  err_clr
);

  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned CW = 10 * LANES;
  localparam int unsigned SW = ERRW + 4;
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  // 5B/6B code for RD- in {a,b,c,d,e,i} order, a in the MSB
  function automatic logic [5:0] tab6(input logic [4:0] x);
    logic [5:0] s;
    case (x)
      5'd0:  s = 6'b100111;
      5'd1:  s = 6'b011101;
      5'd2:  s = 6'b101101;
      5'd3:  s = 6'b110001;
      5'd4:  s = 6'b110101;
      5'd5:  s = 6'b101001;
      5'd6:  s = 6'b011001;
      5'd7:  s = 6'b111000;
      5'd8:  s = 6'b111001;
      5'd9:  s = 6'b100101;
      5'd10: s = 6'b010101;
      5'd11: s = 6'b110100;
      5'd12: s = 6'b001101;
      5'd13: s = 6'b101100;
      5'd14: s = 6'b011100;
      5'd15: s = 6'b010111;
      5'd16: s = 6'b011011;
      5'd17: s = 6'b100011;
      5'd18: s = 6'b010011;
      5'd19: s = 6'b110010;
      5'd20: s = 6'b001011;
      5'd21: s = 6'b101010;
      5'd22: s = 6'b011010;
      5'd23: s = 6'b111010;
      5'd24: s = 6'b110011;
      5'd25: s = 6'b100110;
      5'd26: s = 6'b010110;
      5'd27: s = 6'b110110;
      5'd28: s = 6'b001110;
      5'd29: s = 6'b101110;
      5'd30: s = 6'b011110;
      default: s = 6'b101011;
    endcase
    return s;
  endfunction

  // 3B/4B data code for RD- in {f,g,h,j} order, f in the MSB (primary x.7)
  function automatic logic [3:0] tab4(input logic [2:0] y);
    logic [3:0] t;
    case (y)
      3'd0:    t = 4'b1011;
      3'd1:    t = 4'b1001;
      3'd2:    t = 4'b0101;
      3'd3:    t = 4'b1100;
      3'd4:    t = 4'b1101;
      3'd5:    t = 4'b1010;
      3'd6:    t = 4'b0110;
      default: t = 4'b1110;
    endcase
    return t;
  endfunction

  // K28.x plus K23.7/K27.7/K29.7/K30.7 are the only legal control characters
  function automatic logic legal_k(input logic [7:0] b);
    logic [4:0] x;
    x = b[4:0];
    return (x == 5'd28) ||
           ((b[7:5] == 3'd7) &&
            ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  // Encode one byte from disparity rd; returns {ending rd, code group}
  function automatic logic [10:0] enc_byte(input logic [7:0] b, input logic k,
                                           input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic [5:0] s;
    logic [3:0] t;
    logic       s_unbal;
    logic       t_unbal;
    logic       rd4;
    logic       alt7;
    x   = b[4:0];
    y   = b[7:5];
    k28 = k && (x == 5'd28);
    s   = k28 ? 6'b001111 : tab6(x);
    s_unbal = ($countones(s) != 3);
    // D.7 is balanced but still has distinct RD-/RD+ forms
    if (rd && (s_unbal || (x == 5'd7))) s = ~s;
    rd4 = rd ^ s_unbal;
    // Alternate x.7 avoids a run of five equal bits across the sub-block edge
    alt7 = (y == 3'd7) &&
           (k ||
            (!rd4 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
            ( rd4 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    t = alt7 ? 4'b0111 : tab4(y);
    t_unbal = ($countones(t) != 2);
    if (rd4 && (t_unbal || (y == 3'd3))) t = ~t;
    // K28 balanced 3B/4B codes are inverted when entering from RD- (comma shape)
    if (k28 && !rd4 && !t_unbal && (y != 3'd3)) t = ~t;
    return {rd4 ^ t_unbal, t[0], t[1], t[2], t[3],
            s[0], s[1], s[2], s[3], s[4], s[5]};
  endfunction

  logic [DW-1:0]    sel_data;
  logic [LANES-1:0] sel_k;
  logic             rd_start;
  logic             rd_run;
  logic [10:0]      lane_res;
  logic [CW-1:0]    enc_c;
  logic             rd_end_c;
  logic [LANES-1:0] kerr_c;
  logic [3:0]       kerr_pop;
  logic [SW-1:0]    err_sum;
  logic [ERRW-1:0]  err_next;
  logic             accept;
  logic             load;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = in_ready && (in_valid || IDLE_EN);

  // Beat to encode: the input beat or the idle character on every lane
  assign sel_data = in_valid ? in_data : {LANES{IDLE_CHAR[7:0]}};
  assign sel_k    = in_valid ? in_k    : {LANES{IDLE_CHAR[8]}};
  assign rd_start = rd_clr ? 1'b0 : rd_out;

  // Disparity chain across lanes plus illegal-K detection on the input beat
  always_comb begin
    rd_run   = rd_start;
    lane_res = '0;
    enc_c    = '0;
    kerr_c   = '0;
    kerr_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_res         = enc_byte(sel_data[8*i +: 8], sel_k[i], rd_run);
      enc_c[10*i +: 10] = lane_res[9:0];
      rd_run           = lane_res[10];
      kerr_c[i]        = in_k[i] && !legal_k(in_data[8*i +: 8]);
      kerr_pop         = kerr_pop + 4'(kerr_c[i]);
    end
    rd_end_c = rd_run;
  end

  // Saturating error accumulation
  assign err_sum  = SW'(err_cnt) + SW'(kerr_pop);
  assign err_next = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERRW-1:0];

  // Output register, running disparity and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idle  <= 1'b0;
      out_kerr  <= '0;
      rd_out    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (err_clr) begin
        err_cnt <= '0;
      end else if (accept) begin
        err_cnt <= err_next;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_idle  <= !in_valid;
        out_data  <= enc_c;
        out_kerr  <= in_valid ? kerr_c : '0;
        rd_out    <= rd_end_c;
      end else begin
        if (in_ready) out_valid <= 1'b0;
        if (rd_clr) rd_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed bench for enc8b10b_lanes: a two-lane instance with idle insertion and
// a 4-bit error counter, and a single-lane instance without idle insertion.
module tb_enc8b10b_lanes;

  logic        clk;
  logic        rst;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_idle_a;
  logic [15:0] in_data_a;
  logic [1:0]  in_k_a, out_kerr_a;
  logic [19:0] out_data_a;
  logic        rd_clr_a, rd_out_a, err_clr_a;
  logic [3:0]  err_cnt_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_idle_b;
  logic [7:0]  in_data_b;
  logic [0:0]  in_k_b, out_kerr_b;
  logic [9:0]  out_data_b;
  logic        rd_clr_b, rd_out_b, err_clr_b;
  logic [15:0] err_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  enc8b10b_lanes #(.LANES(2), .IDLE_EN(1'b1), .IDLE_CHAR(9'h1BC), .ERRW(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_k(in_k_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_idle(out_idle_a), .out_kerr(out_kerr_a),
    .rd_clr(rd_clr_a), .rd_out(rd_out_a), .err_cnt(err_cnt_a), .err_clr(err_clr_a)
  );

  enc8b10b_lanes #(.LANES(1), .IDLE_EN(1'b0), .IDLE_CHAR(9'h1BC), .ERRW(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_k(in_k_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_idle(out_idle_b), .out_kerr(out_kerr_b),
    .rd_clr(rd_clr_b), .rd_out(rd_out_b), .err_cnt(err_cnt_b), .err_clr(err_clr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; in_k_a = '0; out_ready_a = 1'b1;
    rd_clr_a = 1'b0; err_clr_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; in_k_b = '0; out_ready_b = 1'b1;
    rd_clr_b = 1'b0; err_clr_b = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst_data_a",  32'(out_data_a),  32'd0);
    chk("rst_idle_a",  32'(out_idle_a),  32'd0);
    chk("rst_kerr_a",  32'(out_kerr_a),  32'd0);
    chk("rst_rd_a",    32'(rd_out_a),    32'd0);
    chk("rst_err_a",   32'(err_cnt_a),   32'd0);
    chk("rst_valid_b", 32'(out_valid_b), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Idle insertion: K28.5 RD- then RD+ across the two lanes
    tick();
    chk("idle_valid", 32'(out_valid_a), 32'd1);
    chk("idle_flag",  32'(out_idle_a),  32'd1);
    chk("idle_data",  32'(out_data_a),  32'h000A0D7C);
    chk("idle_rd",    32'(rd_out_a),    32'd0);
    chk("idle_kerr",  32'(out_kerr_a),  32'd0);
    chk("noidle_b",   32'(out_valid_b), 32'd0);
    chk("ready_b",    32'(in_ready_b),  32'd1);
    tick();
    chk("idle_data2", 32'(out_data_a),  32'h000A0D7C);

    // Single lane K28.5 alternates RD
    in_valid_b = 1'b1; in_k_b = 1'b1; in_data_b = 8'hBC;
    tick();
    chk("b_k285_m",   32'(out_data_b),  32'h17C);
    chk("b_rd1",      32'(rd_out_b),    32'd1);
    chk("b_valid",    32'(out_valid_b), 32'd1);
    chk("b_idle",     32'(out_idle_b),  32'd0);
    tick();
    chk("b_k285_p",   32'(out_data_b),  32'h283);
    chk("b_rd0",      32'(rd_out_b),    32'd0);
    in_valid_b = 1'b0;
    tick();
    chk("b_pulse_end",  32'(out_valid_b), 32'd0);
    chk("b_hold_data",  32'(out_data_b),  32'h283);
    chk("b_hold_rd",    32'(rd_out_b),    32'd0);

    // Two-lane beat {D21.5, K28.5} from RD-
    in_valid_a = 1'b1; in_data_a = 16'hB5BC; in_k_a = 2'b01;
    tick();
    chk("d215_data",  32'(out_data_a),  32'h0005557C);
    chk("d215_rd",    32'(rd_out_a),    32'd1);
    chk("d215_idle",  32'(out_idle_a),  32'd0);
    chk("d215_kerr",  32'(out_kerr_a),  32'd0);

    // Backpressure: same beat pending for 5 cycles
    out_ready_a = 1'b0;
    #1;
    chk("bp_ready",   32'(in_ready_a),  32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data",  32'(out_data_a),  32'h0005557C);
      chk("bp_rd",    32'(rd_out_a),    32'd1);
      chk("bp_ready_hold", 32'(in_ready_a), 32'd0);
    end
    out_ready_a = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready_a),  32'd1);
    tick();
    chk("bp_beat_data", 32'(out_data_a), 32'h00055683);
    chk("bp_beat_rd",   32'(rd_out_a),   32'd0);
    in_valid_a = 1'b0;
    tick();
    chk("bp_after_idle", 32'(out_idle_a), 32'd1);
    chk("bp_after_data", 32'(out_data_a), 32'h000A0D7C);

    // Illegal K0.0 on lane 0
    in_valid_a = 1'b1; in_data_a = 16'hB500; in_k_a = 2'b01;
    tick();
    chk("k00_data",   32'(out_data_a),  32'h000554B9);
    chk("k00_kerr",   32'(out_kerr_a),  32'd1);
    chk("k00_err",    32'(err_cnt_a),   32'd1);
    chk("k00_rd",     32'(rd_out_a),    32'd0);

    // Two illegal lanes per beat: 1+6 then saturation at 15
    in_data_a = 16'h0000; in_k_a = 2'b11;
    tick(); tick(); tick();
    chk("err_7",      32'(err_cnt_a),   32'd7);
    chk("kerr_11",    32'(out_kerr_a),  32'd3);
    for (int i = 0; i < 7; i++) tick();
    chk("err_sat",    32'(err_cnt_a),   32'd15);

    // err_clr wins over a simultaneous illegal lane
    in_data_a = 16'hB500; in_k_a = 2'b01; err_clr_a = 1'b1;
    tick();
    chk("errclr_cnt",  32'(err_cnt_a),  32'd0);
    chk("errclr_kerr", 32'(out_kerr_a), 32'd1);
    err_clr_a = 1'b0; in_valid_a = 1'b0;
    tick();
    chk("idle_nokerr", 32'(out_kerr_a), 32'd0);
    chk("idle_noerr",  32'(err_cnt_a),  32'd0);

    // rd_clr with an advance: beat starts from RD-
    in_valid_a = 1'b1; in_data_a = 16'hB5BC; in_k_a = 2'b01; rd_clr_a = 1'b1;
    tick();
    chk("rdclr_adv_data", 32'(out_data_a), 32'h0005557C);
    chk("rdclr_adv_rd",   32'(rd_out_a),   32'd1);
    // rd_clr without an advance: RD cleared, output held
    out_ready_a = 1'b0;
    tick();
    chk("rdclr_hold_rd",    32'(rd_out_a),    32'd0);
    chk("rdclr_hold_valid", 32'(out_valid_a), 32'd1);
    chk("rdclr_hold_data",  32'(out_data_a),  32'h0005557C);
    rd_clr_a = 1'b0; out_ready_a = 1'b1;
    tick();
    chk("rdclr_next_data", 32'(out_data_a), 32'h0005557C);
    chk("rdclr_next_rd",   32'(rd_out_a),   32'd1);
    in_valid_a = 1'b0;

    // Single lane: rd_clr with K28.5 while RD+
    in_valid_b = 1'b1; in_k_b = 1'b1; in_data_b = 8'hBC;
    tick();
    chk("b_pre_data", 32'(out_data_b), 32'h17C);
    chk("b_pre_rd",   32'(rd_out_b),   32'd1);
    rd_clr_b = 1'b1;
    tick();
    chk("b_rdclr_data", 32'(out_data_b), 32'h17C);
    chk("b_rdclr_rd",   32'(rd_out_b),   32'd1);
    chk("b_kerr",       32'(out_kerr_b), 32'd0);
    chk("b_err",        32'(err_cnt_b),  32'd0);
    rd_clr_b = 1'b0;

    // Asynchronous reset mid-cycle while streaming
    #3 rst = 1'b1;
    #1;
    chk("arst_valid_b", 32'(out_valid_b), 32'd0);
    chk("arst_rd_b",    32'(rd_out_b),    32'd0);
    chk("arst_data_b",  32'(out_data_b),  32'd0);
    chk("arst_valid_a", 32'(out_valid_a), 32'd0);
    chk("arst_rd_a",    32'(rd_out_a),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
